// File: rtl/axi_cut_pkg.sv
// Default AXI4 channel and bundle types for axi_cut. Every type is also a
// parameter of axi_cut, so integrators can substitute their own structs.
package axi_cut_pkg;

  localparam int unsigned IdWidth   = 4;
  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned StrbWidth = DataWidth / 8;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
  } aw_chan_t;

  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic [StrbWidth-1:0] strb;
    logic                 last;
  } w_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0] id;
    axi_resp_e          resp;
  } b_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
  } ar_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [DataWidth-1:0] data;
    axi_resp_e            resp;
    logic                 last;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axi_req_t;

  typedef struct packed {
    logic     aw_ready;
    logic     w_ready;
    b_chan_t  b;
    logic     b_valid;
    logic     ar_ready;
    r_chan_t  r;
    logic     r_valid;
  } axi_rsp_t;

endpackage

// File: rtl/spill_register.sv
// Generic two-entry spill register. Slot A faces the output, slot B catches
// the beat that arrives while A is stalled. Ready, valid and data at the
// outputs come straight from flops, so no input reaches any output
// combinationally. With Bypass set it degenerates to plain wires.
module spill_register #(
  parameter type T      = logic,
  parameter bit  Bypass = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic valid_i,
  output logic ready_o,
  input  T     data_i,
  output logic valid_o,
  input  logic ready_i,
  output T     data_o
);

  if (Bypass) begin : gen_bypass
    assign valid_o = valid_i;
    assign ready_o = ready_i;
    assign data_o  = data_i;
  end else begin : gen_spill
    logic a_full_q, a_full_d;
    logic b_full_q, b_full_d;
    T     a_data_q, a_data_d;
    T     b_data_q, b_data_d;
    logic in_hs, a_drain, b_drain, a_fill, b_fill;

    // Everything visible at the ports is a flop or a mux of flops.
    assign ready_o = !b_full_q;
    assign valid_o = a_full_q | b_full_q;
    assign data_o  = a_full_q ? a_data_q : b_data_q;

    // Slot bookkeeping: A is presented first, B only once A has emptied.
    always_comb begin
      // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
      a_full_d = a_full_q;
      b_full_d = b_full_q;
      a_data_d = a_data_q;
      b_data_d = b_data_q;

      in_hs   = valid_i && !b_full_q;
      a_drain = a_full_q && ready_i;
      b_drain = !a_full_q && b_full_q && ready_i;
      a_fill  = in_hs && (!a_full_q || a_drain);
      b_fill  = in_hs && a_full_q && !a_drain;

      if (a_fill) begin
        a_full_d = 1'b1;
        a_data_d = data_i;
      end else if (a_drain) begin
        a_full_d = 1'b0;
      end

      if (b_fill) begin
        b_full_d = 1'b1;
        b_data_d = data_i;
      end else if (b_drain) begin
        b_full_d = 1'b0;
      end
    end

    // Slot state; a reset drops whatever beats were buffered.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        a_full_q <= 1'b0;
        b_full_q <= 1'b0;
        // NOTE: payload slots are cleared on reset too, so the bus never shows stale data after a reset even though valid already masks it.
        a_data_q <= '0;
        b_data_q <= '0;
      end else begin
        // NOTE: state uses non-blocking assignments so every flop samples the pre-edge values.
        a_full_q <= a_full_d;
        b_full_q <= b_full_d;
        a_data_q <= a_data_d;
        b_data_q <= b_data_d;
      end
    end
  end

endmodule

// File: rtl/axi_cut.sv
// Full AXI4 register slice: each of the five channels runs through its own
// spill register. AW, W and AR flow slave->master, B and R flow back. The
// channels are independent; this module only routes struct fields.
module axi_cut
  import axi_cut_pkg::*;
#(
  parameter bit  Bypass    = 1'b0,
  parameter type aw_chan_t = axi_cut_pkg::aw_chan_t,
  parameter type w_chan_t  = axi_cut_pkg::w_chan_t,
  parameter type b_chan_t  = axi_cut_pkg::b_chan_t,
  parameter type ar_chan_t = axi_cut_pkg::ar_chan_t,
  parameter type r_chan_t  = axi_cut_pkg::r_chan_t,
  parameter type axi_req_t = axi_cut_pkg::axi_req_t,
  parameter type axi_rsp_t = axi_cut_pkg::axi_rsp_t
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  axi_req_t slv_req_i,
  output axi_rsp_t slv_resp_o,
  output axi_req_t mst_req_o,
  input  axi_rsp_t mst_resp_i
);

  aw_chan_t aw_data;
  w_chan_t  w_data;
  ar_chan_t ar_data;
  b_chan_t  b_data;
  r_chan_t  r_data;

  logic aw_valid, aw_ready;
  logic w_valid, w_ready;
  logic ar_valid, ar_ready;
  logic b_valid, b_ready;
  logic r_valid, r_ready;

  spill_register #(.T(aw_chan_t), .Bypass(Bypass)) i_aw_spill (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (slv_req_i.aw_valid),
    .ready_o (aw_ready),
    .data_i  (slv_req_i.aw),
    .valid_o (aw_valid),
    .ready_i (mst_resp_i.aw_ready),
    .data_o  (aw_data)
  );

  spill_register #(.T(w_chan_t), .Bypass(Bypass)) i_w_spill (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (slv_req_i.w_valid),
    .ready_o (w_ready),
    .data_i  (slv_req_i.w),
    .valid_o (w_valid),
    .ready_i (mst_resp_i.w_ready),
    .data_o  (w_data)
  );

  spill_register #(.T(ar_chan_t), .Bypass(Bypass)) i_ar_spill (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (slv_req_i.ar_valid),
    .ready_o (ar_ready),
    .data_i  (slv_req_i.ar),
    .valid_o (ar_valid),
    .ready_i (mst_resp_i.ar_ready),
    .data_o  (ar_data)
  );

  spill_register #(.T(b_chan_t), .Bypass(Bypass)) i_b_spill (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (mst_resp_i.b_valid),
    .ready_o (b_ready),
    .data_i  (mst_resp_i.b),
    .valid_o (b_valid),
    .ready_i (slv_req_i.b_ready),
    .data_o  (b_data)
  );

  spill_register #(.T(r_chan_t), .Bypass(Bypass)) i_r_spill (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (mst_resp_i.r_valid),
    .ready_o (r_ready),
    .data_i  (mst_resp_i.r),
    .valid_o (r_valid),
    .ready_i (slv_req_i.r_ready),
    .data_o  (r_data)
  );

  // Assemble the downstream request from the forward outputs and backward readys.
  always_comb begin
    mst_req_o          = '0;
    mst_req_o.aw       = aw_data;
    mst_req_o.aw_valid = aw_valid;
    mst_req_o.w        = w_data;
    mst_req_o.w_valid  = w_valid;
    mst_req_o.b_ready  = b_ready;
    mst_req_o.ar       = ar_data;
    mst_req_o.ar_valid = ar_valid;
    mst_req_o.r_ready  = r_ready;
  end

  // Assemble the upstream response from the forward readys and backward outputs.
  always_comb begin
    slv_resp_o          = '0;
    slv_resp_o.aw_ready = aw_ready;
    slv_resp_o.w_ready  = w_ready;
    slv_resp_o.b        = b_data;
    slv_resp_o.b_valid  = b_valid;
    slv_resp_o.ar_ready = ar_ready;
    slv_resp_o.r        = r_data;
    slv_resp_o.r_valid  = r_valid;
  end

endmodule

// File: tb/tb_axi_cut.sv
// Directed bench for axi_cut: reset, single beat, streaming, backpressure,
// backward channels with concurrent traffic, and a Bypass=1 instance.
module tb_axi_cut;
  import axi_cut_pkg::*;

  logic     clk;
  logic     rst_n;
  axi_req_t slv_req, mst_req;
  axi_rsp_t slv_resp, mst_resp;

  axi_req_t byp_slv_req, byp_mst_req;
  axi_rsp_t byp_slv_resp, byp_mst_resp;

  int n_tests = 0;
  int n_fail  = 0;

  axi_cut #(
    .Bypass    (1'b0),
    .aw_chan_t (aw_chan_t),
    .w_chan_t  (w_chan_t),
    .b_chan_t  (b_chan_t),
    .ar_chan_t (ar_chan_t),
    .r_chan_t  (r_chan_t),
    .axi_req_t (axi_req_t),
    .axi_rsp_t (axi_rsp_t)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .slv_req_i  (slv_req),
    .slv_resp_o (slv_resp),
    .mst_req_o  (mst_req),
    .mst_resp_i (mst_resp)
  );

  axi_cut #(
    .Bypass    (1'b1),
    .aw_chan_t (aw_chan_t),
    .w_chan_t  (w_chan_t),
    .b_chan_t  (b_chan_t),
    .ar_chan_t (ar_chan_t),
    .r_chan_t  (r_chan_t),
    .axi_req_t (axi_req_t),
    .axi_rsp_t (axi_rsp_t)
  ) dut_byp (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .slv_req_i  (byp_slv_req),
    .slv_resp_o (byp_slv_resp),
    .mst_req_o  (byp_mst_req),
    .mst_resp_i (byp_mst_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Backpressure table (AR channel), one column per cycle.
  logic       bp_in_v   [9] = '{1, 1, 1, 1, 1, 1, 1, 0, 0};
  logic [3:0] bp_in_id  [9] = '{1, 2, 3, 3, 3, 3, 3, 0, 0};
  logic       bp_mrdy   [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 1};
  logic       bp_exp_rdy[9] = '{1, 1, 0, 0, 0, 0, 1, 1, 1};
  logic       bp_exp_v  [9] = '{0, 1, 1, 1, 1, 1, 0, 1, 0};
  logic [3:0] bp_exp_id [9] = '{0, 1, 1, 1, 1, 2, 0, 3, 0};

  initial begin
    rst_n        = 1'b0;
    slv_req      = '0;
    mst_resp     = '0;
    byp_slv_req  = '0;
    byp_mst_resp = '0;

    // ---------------- reset ----------------
    #3;
    slv_req.aw_valid = 1'b1;
    slv_req.aw.addr  = 32'hFFFF_0000;
    #20;
    check("rst_aw_valid_held", mst_req.aw_valid, 0);
    check("rst_aw_ready_held", slv_resp.aw_ready, 1);
    slv_req.aw_valid = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_valids", {mst_req.aw_valid, mst_req.w_valid, mst_req.ar_valid,
                         slv_resp.b_valid, slv_resp.r_valid}, 5'b00000);
    check("rst_readys", {slv_resp.aw_ready, slv_resp.w_ready, slv_resp.ar_ready,
                         mst_req.b_ready, mst_req.r_ready}, 5'b11111);
    check("rst_aw_payload", mst_req.aw.addr, 0);

    mst_resp.aw_ready = 1'b1;
    mst_resp.w_ready  = 1'b1;
    mst_resp.ar_ready = 1'b0;
    slv_req.b_ready   = 1'b1;
    slv_req.r_ready   = 1'b1;

    // ---------------- single AW beat ----------------
    next_cycle();
    slv_req.aw_valid = 1'b1;
    slv_req.aw.addr  = 32'h0000_1000;
    slv_req.aw.id    = 4'd3;
    @(negedge clk);
    check("single_lat_valid", mst_req.aw_valid, 0);
    check("single_in_ready", slv_resp.aw_ready, 1);
    next_cycle();
    slv_req.aw_valid = 1'b0;
    slv_req.aw.addr  = 32'h0;
    @(negedge clk);
    check("single_out_valid", mst_req.aw_valid, 1);
    check("single_out_addr", mst_req.aw.addr, 64'h1000);
    check("single_out_id", mst_req.aw.id, 3);
    next_cycle();
    @(negedge clk);
    check("single_gone", mst_req.aw_valid, 0);

    // ---------------- W streaming ----------------
    for (int i = 0; i < 18; i++) begin
      next_cycle();
      slv_req.w_valid = (i < 16);
      slv_req.w.data  = 32'(i);
      slv_req.w.last  = (i == 15);
      @(negedge clk);
      check("stream_w_ready", slv_resp.w_ready, 1);
      if (i >= 1 && i <= 16) begin
        check("stream_valid", mst_req.w_valid, 1);
        check("stream_data", mst_req.w.data, 64'(i - 1));
      end else begin
        check("stream_idle", mst_req.w_valid, 0);
      end
    end

    // ---------------- AR backpressure ----------------
    for (int c = 0; c < 9; c++) begin
      next_cycle();
      slv_req.ar_valid  = bp_in_v[c];
      slv_req.ar.id     = bp_in_id[c];
      mst_resp.ar_ready = bp_mrdy[c];
      @(negedge clk);
      check($sformatf("bp_in_ready_c%0d", c), slv_resp.ar_ready, bp_exp_rdy[c]);
      check($sformatf("bp_out_valid_c%0d", c), mst_req.ar_valid, bp_exp_v[c]);
      if (bp_exp_v[c])
        check($sformatf("bp_out_id_c%0d", c), mst_req.ar.id, bp_exp_id[c]);
    end

    // ---------------- backward channels + concurrent forward traffic ----------------
    next_cycle();
    mst_resp.b_valid = 1'b1;
    mst_resp.b.id    = 4'd5;
    mst_resp.b.resp  = RESP_OKAY;
    mst_resp.r_valid = 1'b1;
    mst_resp.r.data  = 32'hAA;
    mst_resp.r.last  = 1'b0;
    slv_req.aw_valid = 1'b1;
    slv_req.aw.addr  = 32'h2000;
    slv_req.aw.id    = 4'd7;
    slv_req.w_valid  = 1'b1;
    slv_req.w.data   = 32'hDEAD_BEEF;
    slv_req.w.last   = 1'b1;
    @(negedge clk);
    check("bw_c0_b_valid", slv_resp.b_valid, 0);
    check("bw_c0_r_valid", slv_resp.r_valid, 0);
    check("bw_c0_mst_readys", {mst_req.b_ready, mst_req.r_ready}, 2'b11);

    next_cycle();
    mst_resp.b_valid = 1'b0;
    mst_resp.r.data  = 32'hBB;
    mst_resp.r.last  = 1'b1;
    slv_req.aw_valid = 1'b0;
    slv_req.w_valid  = 1'b0;
    @(negedge clk);
    check("bw_c1_b_valid", slv_resp.b_valid, 1);
    check("bw_c1_b_id", slv_resp.b.id, 5);
    check("bw_c1_r", {slv_resp.r_valid, slv_resp.r.last, slv_resp.r.data}, {2'b10, 32'hAA});
    check("bw_c1_aw", {mst_req.aw_valid, mst_req.aw.id, mst_req.aw.addr}, {1'b1, 4'd7, 32'h2000});
    check("bw_c1_w", {mst_req.w_valid, mst_req.w.data}, {1'b1, 32'hDEAD_BEEF});

    next_cycle();
    mst_resp.r_valid = 1'b0;
    @(negedge clk);
    check("bw_c2_b_valid", slv_resp.b_valid, 0);
    check("bw_c2_r", {slv_resp.r_valid, slv_resp.r.last, slv_resp.r.data}, {2'b11, 32'hBB});
    check("bw_c2_fwd_idle", {mst_req.aw_valid, mst_req.w_valid}, 2'b00);

    next_cycle();
    @(negedge clk);
    check("bw_c3_r_valid", slv_resp.r_valid, 0);

    // ---------------- Bypass=1 ----------------
    byp_slv_req.aw_valid = 1'b1;
    byp_slv_req.aw.addr  = 32'h1234_5678;
    byp_slv_req.w.data   = 32'hCAFE_F00D;
    byp_slv_req.ar.id    = 4'hA;
    byp_slv_req.r_ready  = 1'b1;
    byp_mst_resp.b_valid = 1'b1;
    byp_mst_resp.b.id    = 4'h9;
    byp_mst_resp.r.data  = 32'h0BAD_CAFE;
    byp_mst_resp.w_ready = 1'b1;
    #1;
    check("byp_req_p0", byp_mst_req == byp_slv_req, 1);
    check("byp_rsp_p0", byp_slv_resp == byp_mst_resp, 1);
    check("byp_aw_addr_p0", byp_mst_req.aw.addr, 64'h1234_5678);
    check("byp_r_data_p0", byp_slv_resp.r.data, 64'h0BAD_CAFE);
    byp_slv_req.aw_valid  = 1'b0;
    byp_slv_req.ar_valid  = 1'b1;
    byp_slv_req.ar.addr   = 32'h8000_0004;
    byp_mst_resp.b_valid  = 1'b0;
    byp_mst_resp.r_valid  = 1'b1;
    byp_mst_resp.ar_ready = 1'b1;
    #1;
    check("byp_req_p1", byp_mst_req == byp_slv_req, 1);
    check("byp_rsp_p1", byp_slv_resp == byp_mst_resp, 1);
    check("byp_ar_p1", {byp_mst_req.ar_valid, byp_mst_req.ar.addr}, {1'b1, 32'h8000_0004});
    check("byp_ready_p1", {byp_slv_resp.ar_ready, byp_slv_resp.r_valid}, 2'b11);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
